inv_mix_columns_iter: RTL and testbench

- Sequential InvMixColumns stage of the AES-256 decryption round datapath.
- Takes a 128-bit state from the upstream InvSubBytes/AddRoundKey stage over a valid/ready handshake.
- Applies the inverse column transform one or more columns per cycle, reusing a small number of column-multiplier lanes.
- Presents the result to the next round stage over a valid/ready handshake; a per-block bypass passes the state through unchanged for the final round, which has no InvMixColumns.

---
 rtl/inv_mix_columns_iter.sv | 122 ++++++++++++
 tb/tb_inv_mix_columns_iter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns stage: NUM_LANES column multipliers are reused
// over 4/NUM_LANES cycles; the bypass path serves the final round.
module inv_mix_columns_iter #(
  parameter int NUM_LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int BUSY_CYCLES = 4 / NUM_LANES;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    // Row r of the result rotates the 0E,0B,0D,09 coefficient row by r.
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return r;
  endfunction

  always_comb begin
    int col;
    col         = 0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d = in_data;
          cnt_d  = 2'd0;
          if (in_bypass) begin
            state_d     = DONE;
            out_data_d  = in_data;
            out_valid_d = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        for (int l = 0; l < NUM_LANES; l++) begin
          col = (int'(cnt_q) * NUM_LANES + l) & 3;
          work_d[127-32*col -: 32] = inv_col(work_q[127-32*col -: 32]);
        end
        cnt_d = cnt_q + 2'd1;
        if (int'(cnt_q) == BUSY_CYCLES - 1) begin
          state_d     = DONE;
          cnt_d       = 2'd0;
          out_data_d  = work_d;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      work_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Scoreboard bench for inv_mix_columns_iter: one instance per lane count,
// directed vectors plus a forward-MixColumns round trip with random gaps.
module tb_inv_mix_columns_iter;

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] E2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V3 = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         in_bypass [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] in_data   [3];
  logic [127:0] out_data  [3];

  inv_mix_columns_iter #(.NUM_LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_bypass(in_bypass[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]));
  inv_mix_columns_iter #(.NUM_LANES(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_bypass(in_bypass[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]));
  inv_mix_columns_iter #(.NUM_LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_bypass(in_bypass[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]));

  int checks = 0;
  int failures = 0;
  bit rnd_rdy = 1'b0;
  logic [127:0] exp_q0 [$];
  logic [127:0] exp_q1 [$];
  logic [127:0] exp_q2 [$];

  function automatic int lanes(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Reference forward MixColumns, the inverse of the block under test.
  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [127:0] v);
    case (k)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic pop_check(input int k, input logic [127:0] got);
    logic [127:0] e;
    int n;
    n = (k == 0) ? exp_q0.size() : (k == 1) ? exp_q1.size() : exp_q2.size();
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_output[%0d] got=%h required=none", k, got);
    end else begin
      case (k)
        0: e = exp_q0.pop_front();
        1: e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      chk($sformatf("out_data[%0d]", k), got, e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && out_ready[k]) pop_check(k, out_data[k]);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) begin
      for (int k = 0; k < 3; k++) out_ready[k] = 1'($urandom_range(0, 1));
    end
  end

  // Returns at posedge+1 of the accept edge (or of the out_valid edge when chk_lat).
  task automatic send(input int k, input logic [127:0] d, input bit byp,
                      input logic [127:0] exp, input bit do_push, input bit chk_lat);
    bit acc;
    int lat;
    acc = 1'b0;
    in_data[k] = d;
    in_bypass[k] = byp;
    in_valid[k] = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready[k];
      @(posedge clk);
      #1;
    end
    in_valid[k] = 1'b0;
    in_data[k] = ~d;
    in_bypass[k] = ~byp;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout[%0d] got=no_accept required=accept", k);
      return;
    end
    if (do_push) push_exp(k, exp);
    if (chk_lat) begin
      lat = 0;
      while (!out_valid[k] && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("latency[%0d]", k), 128'(lat), 128'(byp ? 0 : 4 / lanes(k)));
    end
  endtask

  task automatic round_trip(input int k);
    logic [127:0] orig;
    for (int b = 0; b < 1000; b++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(k, fwd_mix(orig), 1'b0, orig, 1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [127:0] held;
    int wait_n;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      in_bypass[k] = 1'b0;
      in_data[k] = '0;
      out_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_in_ready[%0d]", k), 128'(in_ready[k]), 128'(0));
      chk($sformatf("reset_out_valid[%0d]", k), 128'(out_valid[k]), 128'(0));
      chk($sformatf("reset_out_data[%0d]", k), out_data[k], 128'(0));
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", 128'(in_ready[0]), 128'(1));

    for (int k = 0; k < 3; k++) begin
      send(k, V1, 1'b0, E1, 1'b1, 1'b1);
      send(k, V2, 1'b0, E2, 1'b1, 1'b1);
      send(k, V3, 1'b1, V3, 1'b1, 1'b1);
    end

    // Backpressure: the finished block must sit untouched while out_ready is low.
    out_ready[0] = 1'b0;
    send(0, V2, 1'b0, E2, 1'b1, 1'b1);
    held = out_data[0];
    in_valid[0] = 1'b1;
    in_data[0] = V1;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bp_out_data_stable", out_data[0], held);
      chk("bp_in_ready", 128'(in_ready[0]), 128'(0));
      chk("bp_out_valid", 128'(out_valid[0]), 128'(1));
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", 128'(out_valid[0]), 128'(0));

    // Reset in the second BUSY cycle discards the block.
    send(0, V1, 1'b0, E1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      chk("midrst_out_valid", 128'(out_valid[0]), 128'(0));
      chk("midrst_out_data", out_data[0], 128'(0));
    end
    send(0, V2, 1'b0, E2, 1'b1, 1'b1);

    // Reset coincident with a valid request: nothing captured.
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0] = V1;
    in_bypass[0] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid[0] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_accept_out_valid", 128'(out_valid[0]), 128'(0));
    end

    rnd_rdy = 1'b1;
    fork
      round_trip(0);
      round_trip(1);
      round_trip(2);
    join
    @(negedge clk);
    rnd_rdy = 1'b0;
    for (int k = 0; k < 3; k++) out_ready[k] = 1'b1;
    wait_n = 0;
    while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && wait_n < 200) begin
      @(posedge clk);
      #1;
      wait_n++;
    end
    chk("drain_q0", 128'(exp_q0.size()), 128'(0));
    chk("drain_q1", 128'(exp_q1.size()), 128'(0));
    chk("drain_q2", 128'(exp_q2.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
